// File: rtl/fab_gpio_counter.sv
// -----------------------------------------------------------------------------
// fab_gpio_counter
//
// User design for the 28-pad eFPGA GPIO ring, also used as the golden
// reference that the fabric-mapped copy is compared against cycle by cycle.
// It implements a prescaled 24-bit up/down counter with wrap or saturate
// behaviour at the ends of the range.
//
// Ports
//   clk     in   1     system clock, rising edge
//   rst_n   in   1     asynchronous active-low reset
//   io_in   in   IO_W  [0]=clr  [1]=en  [2]=dir (0 up / 1 down)
//                      [3]=sat (0 wrap / 1 saturate)  [IO_W-1:4] unused
//   io_out  out  IO_W  [IO_W-1:4]=counter  [3:1]=0  [0]=tc flag or 0
//   io_oeb  out  IO_W  active-low output enable: [3:0]=1 inputs, rest driven
//
// Configuration
//   FAB_CTR_TC_FLAG_EN  when defined, io_out[0] carries a registered one-cycle
//                       pulse on every step that lands on the terminal value
//                       (all-ones counting up, zero counting down). When
//                       undefined the flag logic is absent and io_out[0]=0.
// -----------------------------------------------------------------------------
module fab_gpio_counter #(
  parameter int IO_W      = 28,
  parameter int CTR_W     = 24,
  parameter int PRESC_DIV = 1    // legal range 1..256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IO_W-1:0] io_in,
  output logic [IO_W-1:0] io_out,
  output logic [IO_W-1:0] io_oeb
);

  localparam int              PRESC_W    = 8;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);
  localparam logic [CTR_W-1:0]   CTR_MAX    = '1;

  // Control pad decode; io_in is already synchronous to clk.
  logic clr;
  logic en;
  logic dir;
  logic sat;

  assign clr = io_in[0];
  assign en  = io_in[1];
  assign dir = io_in[2];
  assign sat = io_in[3];

  // Upper input pads carry no function in this design.
  logic unused_pads;
  assign unused_pads = ^io_in[IO_W-1:4];

  logic [CTR_W-1:0]   ctr;
  logic [PRESC_W-1:0] presc;
  logic               presc_wrap;
  logic               step;
  logic [CTR_W-1:0]   ctr_step;
  logic               flag;

  assign presc_wrap = (presc == PRESC_LAST);
  assign step       = en && presc_wrap;

  // Value the counter would take if it stepped this edge. Saturation is
  // expressed as "stay put" so the flag logic can detect a held value.
  always_comb begin
    // NOTE: default assignment first so no path leaves ctr_step unassigned,
    // which would otherwise infer a latch.
    ctr_step = ctr;
    if (!dir) begin
      if (!(sat && ctr == CTR_MAX)) ctr_step = ctr + CTR_W'(1);
    end else begin
      if (!(sat && ctr == '0))      ctr_step = ctr - CTR_W'(1);
    end
  end

  // NOTE: non-blocking assignments in clocked processes so every register
  // samples the pre-edge values of its sources, matching real flops.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the async reset clears the outputs immediately, independent of
    // clk; the checker compares io_out while reset is still asserted.
    if (!rst_n) begin
      ctr   <= '0;
      presc <= '0;
    end else if (clr) begin
      ctr   <= '0;
      presc <= '0;
    end else if (en) begin
      presc <= presc_wrap ? '0 : presc + PRESC_W'(1);
      if (presc_wrap) ctr <= ctr_step;
    end
  end

`ifdef FAB_CTR_TC_FLAG_EN
  logic tc;

  // Pulse only when a step actually changes the value onto the terminal for
  // the current direction; a saturated hold or a wrap past the end is silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc <= 1'b0;
    end else begin
      tc <= !clr && step && (ctr_step != ctr) &&
            (dir ? (ctr_step == '0) : (ctr_step == CTR_MAX));
    end
  end

  assign flag = tc;
`else
  assign flag = 1'b0;
`endif

  assign io_out = {ctr, 3'b000, flag};
  assign io_oeb = {{(IO_W-4){1'b0}}, 4'hF};

endmodule

// File: tb/tb_fab_gpio_counter.sv
// -----------------------------------------------------------------------------
// tb_fab_gpio_counter
//
// Drives two instances: the default build (PRESC_DIV=1) and a PRESC_DIV=4
// build. A behavioural model computes the expected pad outputs whenever a
// cycle of stimulus is applied; the expectation is queued and compared at
// the following falling edge. Scenario tasks add direct checks of the
// values called out for each scenario.
// -----------------------------------------------------------------------------
module tb_fab_gpio_counter;

`ifdef FAB_CTR_TC_FLAG_EN
  localparam bit TC_EN = 1'b1;
`else
  localparam bit TC_EN = 1'b0;
`endif

  localparam int          MASK    = 'hFFFFFF;
  localparam logic [27:0] OEB_EXP = 28'h000000F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [27:0] io_in = '0;
  logic [27:0] io_out;
  logic [27:0] io_oeb;
  logic [27:0] io_in4 = '0;
  logic [27:0] io_out4;
  logic [27:0] io_oeb4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fab_gpio_counter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_in  (io_in),
    .io_out (io_out),
    .io_oeb (io_oeb)
  );

  fab_gpio_counter #(.PRESC_DIV(4)) dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_in  (io_in4),
    .io_out (io_out4),
    .io_oeb (io_oeb4)
  );

  typedef struct {
    int ctr;
    int presc;
    bit tc;
  } mstate_t;

  mstate_t m;
  mstate_t m4;
  logic [27:0] exp_q[$];
  logic [27:0] exp4_q[$];

  function automatic mstate_t model_reset();
    mstate_t s;
    s.ctr = 0;
    s.presc = 0;
    s.tc = 1'b0;
    return s;
  endfunction

  function automatic mstate_t model_next(mstate_t s, logic [27:0] in, int div);
    mstate_t n = s;
    int old;
    n.tc = 1'b0;
    if (in[0]) begin
      n.ctr = 0;
      n.presc = 0;
    end else if (in[1]) begin
      n.presc = s.presc + 1;
      if (n.presc == div) begin
        n.presc = 0;
        old = s.ctr;
        if (!in[2]) begin
          if (!(in[3] && old == MASK)) n.ctr = (old + 1) & MASK;
          n.tc = (n.ctr != old) && (n.ctr == MASK);
        end else begin
          if (!(in[3] && old == 0)) n.ctr = (old - 1) & MASK;
          n.tc = (n.ctr != old) && (n.ctr == 0);
        end
      end
    end
    return n;
  endfunction

  function automatic logic [27:0] exp_out(mstate_t s);
    logic [23:0] c = s.ctr[23:0];
    return {c, 3'b000, (TC_EN ? s.tc : 1'b0)};
  endfunction

  // Apply one cycle of stimulus to both instances, queue the model's
  // expectation, then compare at the next falling edge.
  task automatic do_cycle(input logic [27:0] in, input logic [27:0] in4);
    logic [27:0] e;
    io_in  = in;
    io_in4 = in4;
    m  = model_next(m, in, 1);
    m4 = model_next(m4, in4, 4);
    exp_q.push_back(exp_out(m));
    exp4_q.push_back(exp_out(m4));
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_main queue empty");
    end else begin
      e = exp_q.pop_front();
      if (io_out !== e) begin
        errors++;
        $display("FAIL sb_main io_out=%h expected=%h", io_out, e);
      end
    end
    checks++;
    if (exp4_q.size() == 0) begin
      errors++;
      $display("FAIL sb_presc4 queue empty");
    end else begin
      e = exp4_q.pop_front();
      if (io_out4 !== e) begin
        errors++;
        $display("FAIL sb_presc4 io_out=%h expected=%h", io_out4, e);
      end
    end
    checks++;
    if (io_oeb !== OEB_EXP || io_oeb4 !== OEB_EXP) begin
      errors++;
      $display("FAIL oeb io_oeb=%h io_oeb4=%h expected=%h", io_oeb, io_oeb4, OEB_EXP);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    io_in = '0;
    io_in4 = '0;
    m = model_reset();
    m4 = model_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (io_out !== 28'h0 || io_out4 !== 28'h0 ||
          io_oeb !== OEB_EXP || io_oeb4 !== OEB_EXP) begin
        errors++;
        $display("FAIL reset cyc=%0d io_out=%h io_out4=%h io_oeb=%h expected out=0 oeb=%h",
                 i, io_out, io_out4, io_oeb, OEB_EXP);
      end
    end
    rst_n = 1'b1;
    do_cycle(28'h0, 28'h0);
    checks++;
    if (io_out !== 28'h0 || io_oeb !== OEB_EXP) begin
      errors++;
      $display("FAIL after_reset io_out=%h io_oeb=%h expected 0/%h", io_out, io_oeb, OEB_EXP);
    end
  endtask

  task automatic test_up_count();
    for (int i = 0; i < 5; i++) do_cycle(28'h1, 28'h0);
    for (int i = 1; i <= 100; i++) begin
      do_cycle(28'h2, 28'h0);
      checks++;
      if (io_out[27:4] !== 24'(i) || io_out[3:0] !== 4'h0) begin
        errors++;
        $display("FAIL up_count ctr=%0d low=%h expected ctr=%0d low=0",
                 io_out[27:4], io_out[3:0], i);
      end
    end
  endtask

  task automatic test_down_wrap();
    do_cycle(28'h1, 28'h0);
    do_cycle(28'h6, 28'h0);
    checks++;
    if (io_out[27:4] !== 24'hFFFFFF || io_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL down_wrap ctr=%h tc=%b expected FFFFFF/0", io_out[27:4], io_out[0]);
    end
    do_cycle(28'h6, 28'h0);
    checks++;
    if (io_out[27:4] !== 24'hFFFFFE) begin
      errors++;
      $display("FAIL down_step ctr=%h expected FFFFFE", io_out[27:4]);
    end
    // Up from FFFFFE reaches the up terminal.
    do_cycle(28'h2, 28'h0);
    checks++;
    if (io_out[27:4] !== 24'hFFFFFF || io_out[0] !== TC_EN) begin
      errors++;
      $display("FAIL up_terminal ctr=%h tc=%b expected FFFFFF/%b", io_out[27:4], io_out[0], TC_EN);
    end
    // Saturated hold at all-ones: no change, no pulse.
    do_cycle(28'hA, 28'h0);
    checks++;
    if (io_out[27:4] !== 24'hFFFFFF || io_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL up_sat_hold ctr=%h tc=%b expected FFFFFF/0", io_out[27:4], io_out[0]);
    end
    do_cycle(28'h2, 28'h0);
    checks++;
    if (io_out[27:4] !== 24'h0 || io_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL up_wrap ctr=%h tc=%b expected 0/0", io_out[27:4], io_out[0]);
    end
    // Count 0->3, then down to 0: pulse on the step that reaches 0 only.
    do_cycle(28'h1, 28'h0);
    for (int i = 0; i < 3; i++) do_cycle(28'h2, 28'h0);
    for (int i = 2; i >= 0; i--) begin
      do_cycle(28'h6, 28'h0);
      checks++;
      if (io_out[27:4] !== 24'(i) || io_out[0] !== ((i == 0) ? TC_EN : 1'b0)) begin
        errors++;
        $display("FAIL down_tc ctr=%0d tc=%b expected %0d/%b", io_out[27:4], io_out[0],
                 i, (i == 0) ? TC_EN : 1'b0);
      end
    end
    do_cycle(28'h6, 28'h0);
    checks++;
    if (io_out[27:4] !== 24'hFFFFFF || io_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL tc_one_cycle ctr=%h tc=%b expected FFFFFF/0", io_out[27:4], io_out[0]);
    end
  endtask

  task automatic test_saturate();
    do_cycle(28'h1, 28'h0);
    for (int i = 0; i < 5; i++) begin
      do_cycle(28'hE, 28'h0);
      checks++;
      if (io_out !== 28'h0) begin
        errors++;
        $display("FAIL down_sat io_out=%h expected 0", io_out);
      end
    end
    for (int i = 1; i <= 3; i++) begin
      do_cycle(28'hA, 28'h0);
      checks++;
      if (io_out[27:4] !== 24'(i)) begin
        errors++;
        $display("FAIL up_sat ctr=%0d expected %0d", io_out[27:4], i);
      end
    end
  endtask

  task automatic test_hold_and_async_reset();
    do_cycle(28'h1, 28'h0);
    for (int i = 0; i < 37; i++) do_cycle(28'h2, 28'h0);
    for (int i = 0; i < 20; i++) begin
      do_cycle(28'h0, 28'h0);
      checks++;
      if (io_out[27:4] !== 24'd37 || io_out[0] !== 1'b0) begin
        errors++;
        $display("FAIL hold ctr=%0d tc=%b expected 37/0", io_out[27:4], io_out[0]);
      end
    end
    // Reset asserted between edges must clear the outputs at once.
    #2;
    rst_n = 1'b0;
    m = model_reset();
    m4 = model_reset();
    #1;
    checks++;
    if (io_out !== 28'h0 || io_out4 !== 28'h0 || io_oeb !== OEB_EXP) begin
      errors++;
      $display("FAIL async_reset io_out=%h io_out4=%h io_oeb=%h expected 0/0/%h",
               io_out, io_out4, io_oeb, OEB_EXP);
    end
    io_in = 28'h2;
    @(negedge clk);
    checks++;
    if (io_out !== 28'h0) begin
      errors++;
      $display("FAIL reset_held io_out=%h expected 0", io_out);
    end
    rst_n = 1'b1;
    do_cycle(28'h2, 28'h0);
    checks++;
    if (io_out[27:4] !== 24'd1) begin
      errors++;
      $display("FAIL reset_release ctr=%0d expected 1", io_out[27:4]);
    end
  endtask

  task automatic test_prescaler();
    do_cycle(28'h0, 28'h1);
    for (int n = 1; n <= 16; n++) begin
      do_cycle(28'h0, 28'h2);
      checks++;
      if (io_out4[27:4] !== 24'(n / 4)) begin
        errors++;
        $display("FAIL presc_step edge=%0d ctr=%0d expected %0d", n, io_out4[27:4], n / 4);
      end
    end
    // Clear two edges into a period; the next step needs four fresh edges.
    do_cycle(28'h0, 28'h2);
    do_cycle(28'h0, 28'h2);
    do_cycle(28'h0, 28'h1);
    for (int n = 1; n <= 4; n++) begin
      do_cycle(28'h0, 28'h2);
      checks++;
      if (io_out4[27:4] !== 24'(n / 4)) begin
        errors++;
        $display("FAIL presc_clr edge=%0d ctr=%0d expected %0d", n, io_out4[27:4], n / 4);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_up_count();
    test_down_wrap();
    test_saturate();
    test_hold_and_async_reset();
    test_prescaler();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
